window_minmax_tracker: RTL and testbench

- Streaming consumer of magnitude comparisons. Accepts WINDOW unsigned samples over a valid/ready input, tracks the running minimum and maximum and the index of each, then presents one result beat over a valid/ready output.
- Sits downstream of the sample source. Instantiates the team's 4-bit-style eq/gt/lt magnitude comparator (correct polarity) as its compare core.

---
 rtl/window_minmax_tracker_pkg.sv | 13 +
 rtl/window_minmax_tracker_mag_compare.sv | 18 +
 rtl/window_minmax_tracker.sv | 133 +++++++++++++
 tb/tb_window_minmax_tracker.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/window_minmax_tracker_pkg.sv
// Shared types and default sizing for the window min/max tracker.
package window_minmax_tracker_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int DEF_WIDTH  = 4;
    localparam int DEF_WINDOW = 8;

endpackage

// File: rtl/window_minmax_tracker_mag_compare.sv
// Unsigned magnitude comparator producing eq/gt/lt of a against b.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module mag_compare #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    assign eq = (a == b);
    assign gt = (a > b);
    assign lt = (a < b);

endmodule

// File: rtl/window_minmax_tracker.sv
// Tracks min/max (earliest index) over WINDOW samples, emits one result beat.
// Latency: result valid on the edge accepting the last sample of the window.
// Backpressure: in_ready drops while a result waits for out_ready.
module window_minmax_tracker
    import window_minmax_tracker_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int WINDOW = DEF_WINDOW,
    parameter int IDXW   = $clog2(WINDOW)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_min,
    output logic [WIDTH-1:0] out_max,
    output logic [IDXW-1:0]  out_min_idx,
    output logic [IDXW-1:0]  out_max_idx
);

    state_t            state, state_nx;
    logic [IDXW-1:0]   count;
    logic [WIDTH-1:0]  min_r, max_r;
    logic [IDXW-1:0]   min_idx_r, max_idx_r;

    logic              min_eq, min_gt, min_lt;
    logic              max_eq, max_gt, max_lt;
    logic              upd_min, upd_max;
    logic              accept, last;
    logic [WIDTH-1:0]  min_nx, max_nx;
    logic [IDXW-1:0]   min_idx_nx, max_idx_nx;

    mag_compare #(.WIDTH(WIDTH)) u_cmp_min (
        .a  (in_data),
        .b  (min_r),
        .eq (min_eq),
        .gt (min_gt),
        .lt (min_lt)
    );

    mag_compare #(.WIDTH(WIDTH)) u_cmp_max (
        .a  (in_data),
        .b  (max_r),
        .eq (max_eq),
        .gt (max_gt),
        .lt (max_lt)
    );

    assign in_ready  = (state != HOLD);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid && in_ready;
    assign last      = (count == IDXW'(WINDOW - 1));

    // Strict compares only: a tie must never move the earliest index.
    assign upd_min = min_lt && !min_eq && !min_gt;
    assign upd_max = max_gt && !max_eq && !max_lt;

    always_comb begin
        min_nx     = min_r;
        max_nx     = max_r;
        min_idx_nx = min_idx_r;
        max_idx_nx = max_idx_r;
        if (state == IDLE) begin
            min_nx     = in_data;
            max_nx     = in_data;
            min_idx_nx = '0;
            max_idx_nx = '0;
        end else begin
            if (upd_min) begin
                min_nx     = in_data;
                min_idx_nx = count;
            end
            if (upd_max) begin
                max_nx     = in_data;
                max_idx_nx = count;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = ACCUM;
            ACCUM:   if (accept && last) state_nx = HOLD;
            HOLD:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (clear) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            min_r       <= '0;
            max_r       <= '0;
            min_idx_r   <= '0;
            max_idx_r   <= '0;
            out_min     <= '0;
            out_max     <= '0;
            out_min_idx <= '0;
            out_max_idx <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (accept) begin
            min_r     <= min_nx;
            max_r     <= max_nx;
            min_idx_r <= min_idx_nx;
            max_idx_r <= max_idx_nx;
            if (state == ACCUM && last) begin
                count       <= '0;
                out_min     <= min_nx;
                out_max     <= max_nx;
                out_min_idx <= min_idx_nx;
                out_max_idx <= max_idx_nx;
            end else begin
                count <= count + IDXW'(1);
            end
        end
    end

endmodule

// File: tb/tb_window_minmax_tracker.sv
// Randomised and directed bench for window_minmax_tracker against a queue-based model.
module tb_window_minmax_tracker;

    localparam int WIDTH  = 4;
    localparam int WINDOW = 8;
    localparam int IDXW   = $clog2(WINDOW);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clear = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_min, out_max;
    logic [IDXW-1:0]  out_min_idx, out_max_idx;

    int checks = 0;
    int failures = 0;

    logic [WIDTH-1:0] win[$];
    int exp_min, exp_max, exp_min_idx, exp_max_idx;

    window_minmax_tracker #(.WIDTH(WIDTH), .WINDOW(WINDOW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_min     (out_min),
        .out_max     (out_max),
        .out_min_idx (out_min_idx),
        .out_max_idx (out_max_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Smallest/largest value in the window, then the first position holding it.
    function automatic void model();
        int lo, hi;
        lo = (1 << WIDTH);
        hi = -1;
        foreach (win[i]) begin
            if (int'(win[i]) < lo) lo = int'(win[i]);
            if (int'(win[i]) > hi) hi = int'(win[i]);
        end
        exp_min = lo;
        exp_max = hi;
        exp_min_idx = -1;
        exp_max_idx = -1;
        foreach (win[i]) begin
            if (exp_min_idx < 0 && int'(win[i]) == lo) exp_min_idx = i;
            if (exp_max_idx < 0 && int'(win[i]) == hi) exp_max_idx = i;
        end
    endfunction

    task automatic push_sample(input logic [WIDTH-1:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
        else tick();
        in_valid = 1'b0;
        in_data  = WIDTH'($urandom);
    endtask

    task automatic check_result();
        model();
        check("out_valid", 32'(out_valid), 32'd1);
        check("in_ready_hold", 32'(in_ready), 32'd0);
        check("out_min", 32'(out_min), 32'(exp_min));
        check("out_max", 32'(out_max), 32'(exp_max));
        check("out_min_idx", 32'(out_min_idx), 32'(exp_min_idx));
        check("out_max_idx", 32'(out_max_idx), 32'(exp_max_idx));
    endtask

    task automatic feed_window(input int start, input int gap_max);
        for (int i = start; i < win.size(); i++) begin
            repeat ($urandom_range(0, gap_max)) tick();
            push_sample(win[i]);
            if (i < win.size() - 1) check("early_valid", 32'(out_valid), 32'd0);
        end
        check_result();
    endtask

    task automatic release_result(input int delay);
        for (int i = 0; i < delay; i++) begin
            tick();
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_min", 32'(out_min), 32'(exp_min));
            check("stall_max_idx", 32'(out_max_idx), 32'(exp_max_idx));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("valid_drop", 32'(out_valid), 32'd0);
        check("ready_back", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #3;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_min", 32'(out_min), 32'd0);
        check("rst_max", 32'(out_max), 32'd0);
        #9 rst_n = 1'b1;
        tick();

        // Mixed window with a duplicated max; out_ready held high throughout.
        out_ready = 1'b1;
        win = '{4'd5, 4'd8, 4'd2, 4'd15, 4'd0, 4'd15, 4'd7, 4'd3};
        feed_window(0, 0);
        tick();
        out_ready = 1'b0;
        check("one_cycle_valid", 32'(out_valid), 32'd0);

        win = '{4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9};
        feed_window(0, 0);
        release_result(0);
        win = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
        feed_window(0, 0);
        release_result(0);

        // Stalled result with in_valid held high: nothing may be consumed.
        win.delete();
        for (int i = 0; i < WINDOW; i++) win.push_back(WIDTH'($urandom));
        feed_window(0, 0);
        in_valid = 1'b1;
        in_data  = 4'd6;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_ready", 32'(in_ready), 32'd0);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_min", 32'(out_min), 32'(exp_min));
            check("bp_max", 32'(out_max), 32'(exp_max));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_drop", 32'(out_valid), 32'd0);
        check("bp_ready_back", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        win = '{4'd6, 4'd10, 4'd3, 4'd12, 4'd6, 4'd1, 4'd14, 4'd2};
        feed_window(1, 1);
        release_result(0);

        // Abort after three samples; the sample in the clear cycle is dropped.
        push_sample(4'd4);
        push_sample(4'd1);
        push_sample(4'd9);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'd0;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clr_valid", 32'(out_valid), 32'd0);
        check("clr_ready", 32'(in_ready), 32'd1);
        check("clr_keep_min", 32'(out_min), 32'(exp_min));
        check("clr_keep_max", 32'(out_max), 32'(exp_max));
        win = '{4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd6};
        feed_window(0, 0);
        release_result(2);

        // Asynchronous reset between edges, mid-window.
        push_sample(4'd11);
        push_sample(4'd3);
        push_sample(4'd13);
        #3 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_ready", 32'(in_ready), 32'd1);
        check("arst_min", 32'(out_min), 32'd0);
        check("arst_max", 32'(out_max), 32'd0);
        check("arst_min_idx", 32'(out_min_idx), 32'd0);
        check("arst_max_idx", 32'(out_max_idx), 32'd0);
        #2 rst_n = 1'b1;
        tick();
        win = '{4'd7, 4'd12, 4'd12, 4'd1, 4'd9, 4'd1, 4'd0, 4'd15};
        feed_window(0, 2);
        release_result(1);

        win = '{4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd8};
        feed_window(0, 3);
        release_result(0);

        for (int w = 0; w < 25; w++) begin
            win.delete();
            for (int i = 0; i < WINDOW; i++) begin
                if (w % 2 == 0) win.push_back(WIDTH'($urandom));
                else win.push_back(WIDTH'($urandom_range(6, 8)));
            end
            feed_window(0, 2);
            release_result($urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
